// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between N_REQ producers in bursts of up to MAX_BURST words.
// Define FIFO_ARB_CNT_EN to add per-requester saturating ack counters (cnt_clr / acc_cnt).
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
`ifdef FIFO_ARB_CNT_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                        full,
    output logic [N_REQ-1:0]            ack,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy,
    output logic                        wr,
    output logic [DATA_WIDTH-1:0]       w_data
`ifdef FIFO_ARB_CNT_EN
    ,
    input  logic                        cnt_clr,
    output logic [N_REQ*CNT_WIDTH-1:0]  acc_cnt
`endif
);

    localparam int                IW        = $clog2(N_REQ);
    localparam int                BW        = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0]     LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [N_REQ-1:0]  ONE_HOT0  = N_REQ'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_d;
    logic [IW-1:0]    last_q, last_d, pick;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
    logic             own_req, terminate;

    // First requester strictly after `last`, wrapping; ties resolved by nearest distance.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] last);
        logic [IW-1:0] sel;
        logic [IW-1:0] cand;
        sel = last;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N_REQ);
            if (r[cand]) sel = cand;
        end
        return sel;
    endfunction

    always_comb begin
        ack    = grant & req & {N_REQ{~full}};
        wr     = |ack;
        busy   = (state_q == BURST);
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign own_req = |(grant & req);
    assign pick    = rr_pick(req, last_q);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        grant_d     = grant;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        terminate   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = BURST;
                    grant_d     = ONE_HOT0 << pick;
                    last_d      = pick;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                terminate = (wr && burst_cnt_q == LAST_BEAT) || !own_req;
                if (terminate) begin
                    // Hand over in the same cycle so back-to-back bursts have no bubble.
                    burst_cnt_d = '0;
                    if (|req) begin
                        grant_d = ONE_HOT0 << pick;
                        last_d  = pick;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (wr) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant       <= '0;
            last_q      <= IW'(N_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_ARB_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [N_REQ];

    // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (ack[i] && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        acc_cnt = '0;
        for (int i = 0; i < N_REQ; i++) acc_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed literal cases plus randomized producers against a queue-free owner/word-count model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
`ifdef FIFO_ARB_CNT_EN
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            full = 1'b0;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic            busy;
    logic            wr;
    logic [DW-1:0]   w_data;
`ifdef FIFO_ARB_CNT_EN
    logic            cnt_clr = 1'b0;
    logic [N*CW-1:0] acc_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)
`ifdef FIFO_ARB_CNT_EN
        , .CNT_WIDTH(CW)
`endif
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .full(full),
        .ack(ack), .grant(grant), .busy(busy), .wr(wr), .w_data(w_data)
`ifdef FIFO_ARB_CNT_EN
        , .cnt_clr(cnt_clr), .acc_cnt(acc_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = '0;
        full  = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    int m_owner = -1;   // -1 = idle
    int m_words = 0;    // words accepted in current burst
    int m_last  = N - 1;
`ifdef FIFO_ARB_CNT_EN
    int m_acks [N];
`endif

    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_ack;
        logic [DW-1:0] e_wd;
        bit            accepted;
        if (reset) begin
            m_owner = -1;
            m_words = 0;
            m_last  = N - 1;
        end
        e_grant = '0;
        e_ack   = '0;
        e_wd    = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_wd = req_data[m_owner*DW +: DW];
            if (req[m_owner] && !full) e_ack[m_owner] = 1'b1;
        end
        accepted = (e_ack != '0);
        check("m_grant", grant, e_grant);
        check("m_ack", ack, e_ack);
        check("m_wr", wr, accepted);
        check("m_wdata", w_data, e_wd);
        check("m_busy", busy, m_owner >= 0);
`ifdef FIFO_ARB_CNT_EN
        for (int i = 0; i < N; i++) begin
            if (reset) m_acks[i] = 0;
            check("m_cnt", acc_cnt[i*CW +: CW], (m_acks[i] > MAXC) ? MAXC : m_acks[i]);
            if (!reset) begin
                if (cnt_clr) m_acks[i] = 0;
                else if (e_ack[i]) m_acks[i] = m_acks[i] + 1;
            end
        end
`endif
        if (!reset) begin
            if (m_owner < 0) begin
                if (req != '0) begin
                    m_owner = rr_next(req, m_last);
                    m_last  = m_owner;
                    m_words = 0;
                end
            end else begin
                if (accepted) m_words++;
                if ((accepted && m_words == MB) || !req[m_owner]) begin
                    m_words = 0;
                    m_owner = rr_next(req, m_last);
                    if (m_owner >= 0) m_last = m_owner;
                end
            end
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    initial begin
        logic [N-1:0] e;
        logic [N-1:0] a;
        int n2;

        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", grant, 4'b0000);
        check("rst_wr", wr, 1'b0);
        check("rst_ack", ack, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_wdata", w_data, 8'h00);

        // Lone requester 0: write next cycle, re-granted after MAX_BURST words.
        reset = 1'b0;
        set_lane(0, 8'hA5);
        req = 4'b0001;
        step();
        check("t1_grant", grant, 4'b0001);
        check("t1_wr", wr, 1'b1);
        check("t1_wdata", w_data, 8'hA5);
        check("t1_ack", ack, 4'b0001);
        repeat (3) begin
            step();
            check("t1_ack_burst", ack, 4'b0001);
        end
        step();
        check("t1_regrant", grant, 4'b0001);
        check("t1_regrant_ack", ack, 4'b0001);

        // All four requesting: round robin, four words each, no idle cycle.
        apply_reset();
        for (int i = 0; i < N; i++) set_lane(i, 8'h10 + 8'(i));
        req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            e = 4'(1 << (b % N));
            for (int w = 0; w < MB; w++) begin
                step();
                check("t2_grant", grant, e);
                check("t2_ack", ack, e);
                check("t2_wdata", w_data, 8'h10 + 8'(b % N));
            end
        end

        // Owner 1 stalled by full for 3 cycles, then finishes its 4 words.
        apply_reset();
        set_lane(1, 8'h3C);
        req = 4'b0010;
        step();
        check("t3_w1", ack, 4'b0010);
        req = 4'b0011;
        step();
        check("t3_w2", ack, 4'b0010);
        for (int c = 0; c < 3; c++) begin
            step();
            full = 1'b1;
            #1;
            check("t3_full_wr", wr, 1'b0);
            check("t3_full_ack", ack, 4'b0000);
            check("t3_full_grant", grant, 4'b0010);
        end
        step();
        full = 1'b0;
        #1;
        check("t3_w3", ack, 4'b0010);
        step();
        check("t3_w4", ack, 4'b0010);
        step();
        check("t3_handover", grant, 4'b0001);

        // Owner 2 drops req after 2 words; requester 0 takes over next cycle.
        apply_reset();
        n2 = 0;
        req = 4'b0100;
        step();
        n2 += int'(ack[2]);
        step();
        n2 += int'(ack[2]);
        step();
        req = 4'b0001;
        #1;
        n2 += int'(ack[2]);
        check("t4_drop_ack", ack, 4'b0000);
        check("t4_drop_grant", grant, 4'b0100);
        step();
        n2 += int'(ack[2]);
        check("t4_next_grant", grant, 4'b0001);
        check("t4_lane2_acks", n2, 2);

        // Async reset mid-burst clears outputs before any clock edge.
        apply_reset();
        req = 4'b1111;
        step();
        step();
        check("t5_wr_before", wr, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("t5_async_wr", wr, 1'b0);
        check("t5_async_ack", ack, 4'b0000);
        check("t5_async_grant", grant, 4'b0000);
        check("t5_async_busy", busy, 1'b0);
        step();
        req   = 4'b1000;
        reset = 1'b0;
        step();
        check("t5_after_grant", grant, 4'b1000);

`ifdef FIFO_ARB_CNT_EN
        // Lane 3 counter saturates, then clear wins over a same-cycle ack.
        apply_reset();
        req = 4'b1000;
        repeat (21) step();
        check("cnt_sat_lane3", acc_cnt[3*CW +: CW], 4'hF);
        check("cnt_lane0", acc_cnt[0 +: CW], 4'h0);
        check("cnt_ack_live", ack, 4'b1000);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        #1;
        check("cnt_clr_lane3", acc_cnt[3*CW +: CW], 4'h0);
`endif

        // Randomized producers obeying the hold-until-ack rule.
        apply_reset();
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a = ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (a[i]) begin
                        if ($urandom_range(9) < 7) set_lane(i, DW'($urandom));
                        else req[i] = 1'b0;
                    end else if ($urandom_range(99) < 3) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(99) < 30) begin
                    req[i] = 1'b1;
                    set_lane(i, DW'($urandom));
                end
            end
            full = ($urandom_range(99) < 20);
`ifdef FIFO_ARB_CNT_EN
            cnt_clr = ($urandom_range(99) < 2);
`endif
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one fifo write port between N_REQ producers.
- Grants one producer at a time for a burst of up to MAX_BURST words.
- Drives the fifo wr/w_data inputs and observes fifo full.
- Returns a per-word accept strobe (ack) to the granted producer. Sits directly in front of the fifo write side.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, word width, matches fifo DATA_WIDTH
MAX_BURST, 4, max words accepted per grant (>=1)
CNT_WIDTH, 16, per-requester counter width (only with FIFO_ARB_CNT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  req[i]=1: producer i has a word on its data lane
req_data  input  N_REQ*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
full  input  1  fifo full flag
ack  output  N_REQ  one-hot; ack[i]=1: lane i word written this cycle
grant  output  N_REQ  registered one-hot current owner, 0 when idle
busy  output  1  state==BURST
wr  output  1  fifo write strobe
w_data  output  DATA_WIDTH  fifo write data

Behaviour:
- Reset (async, immediate):
  - state=IDLE, grant=0, burst_cnt=0, last pointer=N_REQ-1, so requester 0 wins first.
  - Combinational outputs follow: wr=0, ack=0, busy=0, w_data=0.
- Output decode (combinational from the grant register):
  - wr = |(grant & req) & ~full.
  - ack = grant & req & {N_REQ{~full}}.
  - w_data = granted lane; 0 when grant==0.
- Next-owner selection:
  - First set bit of req, searching from last+1 upward and wrapping modulo N_REQ.
  - last updates to the granted index whenever a grant is loaded.
- FSM IDLE:
  - If req!=0, load grant and enter BURST with burst_cnt=0.
  - Arbitration latency is 1 cycle: the first write occurs the cycle after req rises.
- FSM BURST (owner g):
  - Accept cycle (ack[g]=1): burst_cnt++.
  - Terminate when burst_cnt==MAX_BURST-1 on an accept cycle, or when req[g]==0.
  - On terminate: if any req is set (evaluated with g as last), load the next grant the same cycle with no bubble. Otherwise go to IDLE with grant=0.
  - A lone requester that is still requesting is re-granted to itself.
- Full stall:
  - While full=1 the owner keeps the grant, no ack, burst_cnt holds. There is no timeout.
  - Writing resumes the cycle full drops.
- Producer rules:
  - Hold req and lane data stable until ack.
  - Dropping req with no ack is legal and ends the burst without writing.
- Width: burst_cnt is $clog2(MAX_BURST)+1 bits.
- MAX_BURST=1 gives word-interleaved round robin: one word per grant.
- The arbiter never asserts wr while full=1, so no word is lost at the fifo.

Optional Feature:
- FIFO_ARB_CNT_EN defined:
  - Adds input cnt_clr (1) and output acc_cnt (N_REQ*CNT_WIDTH).
  - Lane i counts ack[i] pulses and saturates at all-ones.
  - cnt_clr=1 zeroes all counters synchronously and has priority over a same-cycle increment.
  - Reset zeroes all counters.
- Undefined: the ports and counters are absent. Arbitration is identical.

Test Plan:
- Reset, then req=4'b0001, full=0, lane0=8'hA5 -> cycle 1 grant=0001, wr=1, w_data=A5, ack=0001; after 4 acks grant re-loads 0001.
- req=4'b1111 held, MAX_BURST=4, full=0 -> grants 0001,0010,0100,1000,0001 in order, exactly 4 acks each, no idle cycle between bursts.
- Owner 1 mid-burst, full=1 for 3 cycles -> wr=0, ack=0, grant stays 0010, burst_cnt unchanged; remaining words written after full drops.
- Owner 2 drops req after 2 words, req[0]=1 -> next cycle grant=0001; requester 2 receives only 2 acks.
- Assert reset while wr=1 mid-burst -> wr, ack, grant go to 0 within the same cycle without waiting for a clock edge; after release, req=1000 gives grant=1000 one cycle later.
- FIFO_ARB_CNT_EN, CNT_WIDTH=4, 20 acks on lane 3 -> acc_cnt lane3=4'hF; cnt_clr together with an ack -> 0.
